// File: rtl/morse_round_controller.sv
// Multi-round game sequencer for the Morse trainer: login-gated session, per-round countdown,
// lives budget and answer judging, with all outputs registered.
module morse_round_controller #(
   parameter int unsigned ROUNDS     = 4,
   parameter int unsigned LIVES      = 3,
   parameter int unsigned TIMER_W    = 16,
   parameter int unsigned LIMIT_EASY = 1000,
   parameter int unsigned LIMIT_NORM = 500,
   parameter int unsigned LIMIT_HARD = 250,
   localparam int unsigned RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1,
   localparam int unsigned LW = $clog2(LIVES + 1),
   localparam int unsigned SW = $clog2(ROUNDS + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               logged_in,
   input  logic               pass_enter,
   input  logic [1:0]         mode,
   input  logic               answer_valid,
   input  logic               answer_correct,
   output logic               enable,
   output logic               timer_load,
   output logic [TIMER_W-1:0] time_left,
   output logic [RW-1:0]      round_idx,
   output logic [LW-1:0]      lives_left,
   output logic [SW-1:0]      score,
   output logic               round_timeout,
   output logic               game_over,
   output logic               game_won
);

   typedef enum logic [2:0] {StIdle, StArmed, StLoad, StPlay, StJudge, StOver} state_e;

   localparam logic [1:0]  ModeNorm    = 2'b01;
   localparam logic [1:0]  ModeHard    = 2'b10;
   localparam logic [1:0]  ModeRestart = 2'b11;
   localparam logic [RW-1:0] LastRound = RW'(ROUNDS - 1);

   state_e               state_q, state_d;
   logic [1:0]           diff_q, diff_d;
   logic [TIMER_W-1:0]   time_q, time_d;
   logic [RW-1:0]        round_q, round_d;
   logic [LW-1:0]        lives_q, lives_d;
   logic [SW-1:0]        score_q, score_d;
   logic                 timeout_d;
   logic                 enable_q, timer_load_q, timeout_q, over_q, won_q;
   logic [TIMER_W-1:0]   limit;

   always_comb begin
      case (diff_q)
         ModeNorm: limit = TIMER_W'(LIMIT_NORM);
         ModeHard: limit = TIMER_W'(LIMIT_HARD);
         default:  limit = TIMER_W'(LIMIT_EASY);
      endcase
   end

   always_comb begin
      state_d   = state_q;
      diff_d    = diff_q;
      time_d    = time_q;
      round_d   = round_q;
      lives_d   = lives_q;
      score_d   = score_q;
      timeout_d = 1'b0;
      // Logout and restart abort any game in progress and clear every counter.
      if (state_q != StIdle && (!logged_in || (pass_enter && mode == ModeRestart))) begin
         state_d = StIdle;
         diff_d  = '0;
         time_d  = '0;
         round_d = '0;
         lives_d = '0;
         score_d = '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (logged_in) state_d = StArmed;
            end
            StArmed: begin
               if (pass_enter) begin
                  diff_d  = mode;
                  lives_d = LW'(LIVES);
                  round_d = '0;
                  score_d = '0;
                  state_d = StLoad;
               end
            end
            StLoad: begin
               time_d  = limit;
               state_d = StPlay;
            end
            StPlay: begin
               if (answer_valid) begin
                  if (answer_correct) score_d = score_q + SW'(1);
                  else if (lives_q != '0) lives_d = lives_q - LW'(1);
                  state_d = StJudge;
               end else if (time_q == '0) begin
                  if (lives_q != '0) lives_d = lives_q - LW'(1);
                  timeout_d = 1'b1;
                  state_d   = StJudge;
               end else begin
                  time_d = time_q - TIMER_W'(1);
               end
            end
            StJudge: begin
               if (lives_q == '0 || round_q == LastRound) begin
                  state_d = StOver;
               end else begin
                  round_d = round_q + RW'(1);
                  state_d = StLoad;
               end
            end
            StOver: begin
               if (pass_enter && mode == ModeNorm) state_d = StArmed;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         diff_q       <= '0;
         time_q       <= '0;
         round_q      <= '0;
         lives_q      <= '0;
         score_q      <= '0;
         enable_q     <= 1'b0;
         timer_load_q <= 1'b0;
         timeout_q    <= 1'b0;
         over_q       <= 1'b0;
         won_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         diff_q       <= diff_d;
         time_q       <= time_d;
         round_q      <= round_d;
         lives_q      <= lives_d;
         score_q      <= score_d;
         enable_q     <= (state_d == StPlay);
         timer_load_q <= (state_d == StLoad);
         timeout_q    <= timeout_d;
         over_q       <= (state_d == StOver);
         won_q        <= (state_d == StOver) && (lives_d != '0);
      end
   end

   assign enable        = enable_q;
   assign timer_load    = timer_load_q;
   assign time_left     = time_q;
   assign round_idx     = round_q;
   assign lives_left    = lives_q;
   assign score         = score_q;
   assign round_timeout = timeout_q;
   assign game_over     = over_q;
   assign game_won      = won_q;

endmodule

// File: doc/morse_round_controller.md
# morse_round_controller

Parametrised multi-round game sequencer for the Morse decoder trainer. It runs a login-gated session of `ROUNDS` rounds with a per-difficulty countdown timer and a lives budget, and judges each player answer. It reports score, round index and win/lose status to the display and feedback logic. It sits between the login/password path and the symbol decoder, and gates decoder input through `enable`.

## Interface
- `ROUNDS`, default 4: rounds per game, ≥1.
- `LIVES`, default 3: wrong answers or timeouts tolerated before a loss, ≥1.
- `TIMER_W`, default 16: countdown width.
- `LIMIT_EASY`, default 1000: round length in cycles for mode 00.
- `LIMIT_NORM`, default 500: round length in cycles for mode 01.
- `LIMIT_HARD`, default 250: round length in cycles for mode 10.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `logged_in`  in  1  session valid level from the login block.
- `pass_enter`  in  1  one-cycle confirm pulse, already debounced.
- `mode`  in  2  00 easy, 01 normal/replay, 10 hard, 11 restart.
- `answer_valid`  in  1  one-cycle pulse: decoder has a complete answer.
- `answer_correct`  in  1  qualifies `answer_valid`.
- `enable`  out  1  decoder input enable.
- `timer_load`  out  1  one-cycle pulse at each round start.
- `time_left`  out  TIMER_W  remaining cycles in the current round.
- `round_idx`  out  max(1,clog2(ROUNDS))  current round, 0-based.
- `lives_left`  out  clog2(LIVES+1)  remaining lives.
- `score`  out  clog2(ROUNDS+1)  correct answers this game.
- `round_timeout`  out  1  one-cycle pulse when a round expires.
- `game_over`  out  1  level, high in OVER.
- `game_won`  out  1  level, high in OVER when `lives_left>0`.

## Operation
- States: IDLE, ARMED, LOAD, PLAY, JUDGE, OVER.
- All outputs are registered.
- Reset value: state IDLE; every output 0, including `time_left`, `lives_left` and `score`.
- Priority each cycle:
  1. `logged_in`=0 in any non-IDLE state → IDLE, all counters cleared.
  2. `pass_enter` with `mode`=11 in any non-IDLE state → IDLE, all counters cleared.
  3. Normal transitions below.
- IDLE: `logged_in`=1 → ARMED.
- ARMED: `pass_enter` with mode 00, 01 or 10:
  - latch difficulty;
  - `lives_left`←LIVES, `round_idx`←0, `score`←0;
  - → LOAD.
- LOAD (1 cycle): `time_left`←LIMIT of the latched difficulty; `timer_load`=1; → PLAY.
- PLAY: `enable`=1. Each cycle, in order:
  - `answer_valid`: if `answer_correct`, `score`+1; otherwise `lives_left`−1. → JUDGE.
  - else `time_left`==0: `lives_left`−1; `round_timeout` pulses; → JUDGE.
  - else `time_left`−1.
- Simultaneous answer and expiry: the answer wins; no timeout pulse.
- JUDGE (1 cycle):
  - `lives_left`==0 → OVER (lost);
  - else `round_idx`==ROUNDS−1 → OVER (won);
  - else `round_idx`+1 → LOAD.
- OVER: `game_over`=1, `game_won`=(`lives_left`≠0). Counters hold. `pass_enter` with `mode`=01 → ARMED (replay in the same login).
- `answer_valid` outside PLAY is ignored.
- `pass_enter` in LOAD, PLAY or JUDGE is ignored unless `mode`=11.
- Arithmetic:
  - `lives_left` decrement saturates at 0.
  - `score` never exceeds ROUNDS by construction.
  - `time_left` never wraps: it holds at 0 on exit from PLAY.

## Timing
- Login to decoder enabled: `logged_in`↑ → ARMED next edge; `pass_enter` → LOAD next edge; `enable`=1 two edges after `pass_enter`.
- Round length without an answer: LIMIT+1 PLAY cycles; `round_timeout` is seen the cycle after the last PLAY cycle.
- Answer to next round: `answer_valid` → JUDGE next edge → LOAD → PLAY, so 3 edges until `enable` reasserts.
- `enable` drops the edge after `answer_valid` or expiry.
- Asynchronous reset mid-round: all outputs 0 immediately; state IDLE.

## Test plan
- Reset: hold `rst`=0 during PLAY → all outputs 0 with no clock edge; release → IDLE.
- Clean win: ROUNDS=4, easy; 4 correct answers at PLAY cycle 5 → `score`=4, `lives_left`=3, `game_won`=1, `timer_load` pulsed 4 times.
- Loss by timeout: LIMIT_HARD=10, hard, no answers → `round_timeout` each time after 11 PLAY cycles; OVER after round 2 with `lives_left`=0, `game_won`=0.
- Collision: `answer_valid` with correct in the cycle `time_left`==0 → `score`+1, no `round_timeout`, `lives_left` unchanged.
- Restart and replay: mode 11 `pass_enter` in PLAY → IDLE, counters 0. In OVER, mode 01 `pass_enter` → ARMED; a new game reloads `lives_left`=3, `score`=0.
- Logout: drop `logged_in` in JUDGE → IDLE next edge; `pass_enter` mode 00 afterwards is ignored until `logged_in` returns.
